// File: rtl/spi_cs_arbiter.sv
// -----------------------------------------------------------------------------
// spi_cs_arbiter
//
// Shares one SPI host between NumDev chip-selected peripherals. Requests are
// served one at a time in round-robin order. The owner's active-low chip
// select is framed by programmable setup, hold and inter-transfer gap times,
// and sel_o steers the host data mux.
//
// Ports:
//   clk_i   in   1                system clock
//   rst_i   in   1                synchronous active-high reset
//   req_i   in   NumDev           per-device request level, held until done
//   done_i  in   NumDev           per-device one-cycle end-of-transfer pulse
//   gnt_o   out  NumDev           one-hot grant while the device owns the host
//   cs_no   out  NumDev           active-low chip selects, at most one low
//   sel_o   out  $clog2(NumDev)   index of current/last owner (host mux)
//   busy_o  out  1                high whenever the arbiter is not idle
// -----------------------------------------------------------------------------
module spi_cs_arbiter #(
    parameter int NumDev      = 4,
    parameter int SetupCycles = 2,
    parameter int HoldCycles  = 2,
    parameter int GapCycles   = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NumDev-1:0]         req_i,
    input  logic [NumDev-1:0]         done_i,
    output logic [NumDev-1:0]         gnt_o,
    output logic [NumDev-1:0]         cs_no,
    output logic [$clog2(NumDev)-1:0] sel_o,
    output logic                      busy_o
);

    localparam int SelW   = $clog2(NumDev);
    localparam int MaxSH  = (SetupCycles > HoldCycles) ? SetupCycles : HoldCycles;
    localparam int MaxCyc = (MaxSH > GapCycles) ? MaxSH : GapCycles;
    localparam int CntW   = $clog2(MaxCyc + 1);

    localparam logic [CntW-1:0] SetupLd = CntW'(SetupCycles - 1);
    localparam logic [CntW-1:0] HoldLd  = CntW'(HoldCycles - 1);
    localparam logic [CntW-1:0] GapLd   = CntW'(GapCycles - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ACTIVE,
        S_HOLD,
        S_GAP
    } state_e;

    state_e             r_state;
    logic [CntW-1:0]    r_cnt;
    logic [SelW-1:0]    r_last;
    logic [SelW-1:0]    r_sel;
    logic [NumDev-1:0]  r_gnt;
    logic [NumDev-1:0]  r_cs_n;
    logic               r_busy;

    state_e             w_state_nxt;
    logic [CntW-1:0]    w_cnt_nxt;
    logic [SelW-1:0]    w_last_nxt;
    logic [SelW-1:0]    w_sel_nxt;
    logic [NumDev-1:0]  w_gnt_nxt;
    logic [NumDev-1:0]  w_cs_n_nxt;

    logic               w_found;
    logic [SelW-1:0]    w_winner;

    // Round-robin search: the device just after the last owner is looked at
    // first, wrapping around, so the last owner itself has lowest priority.
    always_comb begin
        int idx;
        idx      = 0;
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = 1; k <= NumDev; k++) begin
            idx = (int'(r_last) + k) % NumDev;
            if (!w_found && req_i[SelW'(idx)]) begin
                w_found  = 1'b1;
                w_winner = SelW'(idx);
            end
        end
    end

    // NOTE: every output of this block is given a hold-value default first, so
    // no path through the case statement can leave a latch behind.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_last_nxt  = r_last;
        w_sel_nxt   = r_sel;
        w_gnt_nxt   = r_gnt;
        w_cs_n_nxt  = r_cs_n;

        unique case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_sel_nxt   = w_winner;
                    w_cs_n_nxt  = ~(NumDev'(1) << w_winner);
                    w_cnt_nxt   = SetupLd;
                    w_state_nxt = S_SETUP;
                end
            end
            S_SETUP: begin
                // A requester that gives up before its grant still gets the
                // full hold/gap framing so the peripheral sees a clean CS.
                if (!req_i[r_sel]) begin
                    w_cnt_nxt   = HoldLd;
                    w_state_nxt = S_HOLD;
                end else if (r_cnt == '0) begin
                    w_gnt_nxt   = NumDev'(1) << r_sel;
                    w_state_nxt = S_ACTIVE;
                end else begin
                    w_cnt_nxt = r_cnt - CntW'(1);
                end
            end
            S_ACTIVE: begin
                // Only the owner's done/req matter; other done pulses are noise.
                if (done_i[r_sel] || !req_i[r_sel]) begin
                    w_gnt_nxt   = '0;
                    w_cnt_nxt   = HoldLd;
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (r_cnt == '0) begin
                    w_cs_n_nxt  = '1;
                    w_last_nxt  = r_sel;
                    w_cnt_nxt   = GapLd;
                    w_state_nxt = S_GAP;
                end else begin
                    w_cnt_nxt = r_cnt - CntW'(1);
                end
            end
            S_GAP: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - CntW'(1);
                end
            end
            default: begin
                w_gnt_nxt   = '0;
                w_cs_n_nxt  = '1;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the values from before this edge, independent of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_last  <= SelW'(NumDev - 1);
            r_sel   <= '0;
            r_gnt   <= '0;
            r_cs_n  <= '1;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_last  <= w_last_nxt;
            r_sel   <= w_sel_nxt;
            r_gnt   <= w_gnt_nxt;
            r_cs_n  <= w_cs_n_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
        end
    end

    assign gnt_o  = r_gnt;
    assign cs_no  = r_cs_n;
    assign sel_o  = r_sel;
    assign busy_o = r_busy;

endmodule

// File: tb/tb_spi_cs_arbiter.sv
// -----------------------------------------------------------------------------
// tb_spi_cs_arbiter
//
// Three arbiter instances: defaults (2/2/4), fast (1/1/1) and slow (5/3/7)
// setup/hold/gap. Expected grant order is pushed to a scoreboard queue when
// requests are driven and popped when a grant appears. Timing expectations are
// constants derived from the setup/hold/gap values of each instance.
// -----------------------------------------------------------------------------
module tb_spi_cs_arbiter;

    localparam int K_CS_LOW  = 0;
    localparam int K_GNT     = 1;
    localparam int K_CS_HIGH = 3;
    localparam int K_IDLE    = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       mon_en = 1'b0;
    logic [3:0] req  [3];
    logic [3:0] done [3];
    logic [3:0] gnt  [3];
    logic [3:0] cs_n [3];
    logic [1:0] sel  [3];
    logic       busy [3];

    int setup_c [3] = '{2, 1, 5};
    int hold_c  [3] = '{2, 1, 3};
    int gap_c   [3] = '{4, 1, 7};

    int n_checks = 0;
    int n_pass   = 0;
    int inv_bad [3] = '{0, 0, 0};
    int gnt_cyc [3] = '{0, 0, 0};
    int exp_gnt [$];

    always #5 clk = ~clk;

    spi_cs_arbiter #(.NumDev(4), .SetupCycles(2), .HoldCycles(2), .GapCycles(4)) u_dut_def (
        .clk_i(clk), .rst_i(rst), .req_i(req[0]), .done_i(done[0]),
        .gnt_o(gnt[0]), .cs_no(cs_n[0]), .sel_o(sel[0]), .busy_o(busy[0]));

    spi_cs_arbiter #(.NumDev(4), .SetupCycles(1), .HoldCycles(1), .GapCycles(1)) u_dut_fast (
        .clk_i(clk), .rst_i(rst), .req_i(req[1]), .done_i(done[1]),
        .gnt_o(gnt[1]), .cs_no(cs_n[1]), .sel_o(sel[1]), .busy_o(busy[1]));

    spi_cs_arbiter #(.NumDev(4), .SetupCycles(5), .HoldCycles(3), .GapCycles(7)) u_dut_slow (
        .clk_i(clk), .rst_i(rst), .req_i(req[2]), .done_i(done[2]),
        .gnt_o(gnt[2]), .cs_no(cs_n[2]), .sel_o(sel[2]), .busy_o(busy[2]));

    // Invariant monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int d = 0; d < 3; d++) begin
                if (!$onehot0(gnt[d]) || ($countones(~cs_n[d]) > 1) ||
                    ((gnt[d] & cs_n[d]) !== 4'b0000))
                    inv_bad[d]++;
                if (gnt[d] !== 4'b0000)
                    gnt_cyc[d]++;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic check4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        check(tag, {28'b0, obs}, {28'b0, exp});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic cond(input int d, input int kind);
        case (kind)
            K_CS_LOW:  return cs_n[d] !== 4'b1111;
            K_GNT:     return gnt[d] !== 4'b0000;
            K_CS_HIGH: return cs_n[d] === 4'b1111;
            default:   return busy[d] === 1'b0;
        endcase
    endfunction

    // Counts edges until the condition holds; -1 when the budget runs out.
    task automatic wait_for(input int d, input int kind, input int budget, output int n);
        n = 0;
        while (!cond(d, kind) && n < budget) begin
            step();
            n++;
        end
        if (!cond(d, kind))
            n = -1;
    endtask

    // Counts sampled cycles with all CS high, and how many of those are busy.
    task automatic gap_measure(input int d, output int hi, output int hb);
        hi = 0;
        hb = 0;
        while (cs_n[d] === 4'b1111 && hi < 40) begin
            hi++;
            if (busy[d] === 1'b1)
                hb++;
            step();
        end
    endtask

    function automatic int oh_idx(input logic [3:0] v);
        if (!$onehot(v))
            return -1;
        for (int i = 0; i < 4; i++)
            if (v[i])
                return i;
        return -1;
    endfunction

    task automatic observe_gnt(input string tag, input int d);
        int e;
        check({tag, "_sb_nonempty"}, 32'(exp_gnt.size() != 0), 1);
        if (exp_gnt.size() != 0) begin
            e = exp_gnt.pop_front();
            check(tag, 32'(oh_idx(gnt[d])), 32'(e));
        end
    endtask

    initial begin
        int n;
        int g;
        int hi;
        int hb;
        int c0;
        int bad_cs;
        int bad_gnt;
        int bad_sel;
        int bad_busy;

        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            req[d]  = 4'b0000;
            done[d] = 4'b0000;
        end
        repeat (3) step();
        rst = 1'b0;
        mon_en = 1'b1;

        // Reset then idle with no requests for 20 cycles.
        bad_cs = 0; bad_gnt = 0; bad_sel = 0; bad_busy = 0;
        for (int i = 0; i < 20; i++) begin
            if (cs_n[0] !== 4'b1111) bad_cs++;
            if (gnt[0]  !== 4'b0000) bad_gnt++;
            if (sel[0]  !== 2'd0)    bad_sel++;
            if (busy[0] !== 1'b0)    bad_busy++;
            step();
        end
        check("idle_cs_cycles",   32'(bad_cs),   0);
        check("idle_gnt_cycles",  32'(bad_gnt),  0);
        check("idle_sel_cycles",  32'(bad_sel),  0);
        check("idle_busy_cycles", 32'(bad_busy), 0);
        check4("idle_cs_fast", cs_n[1], 4'b1111);
        check4("idle_cs_slow", cs_n[2], 4'b1111);

        // Single request on device 2 with default timing.
        exp_gnt.push_back(2);
        req[0] = 4'b0100;
        wait_for(0, K_CS_LOW, 10, n);
        check("single_cs_lat", 32'(n), 1);
        check4("single_cs_vec", cs_n[0], 4'b1011);
        check("single_busy", {31'b0, busy[0]}, 1);
        check("single_sel", {30'b0, sel[0]}, 2);
        wait_for(0, K_GNT, 10, n);
        check("single_gnt_lat", 32'(n), 2);
        observe_gnt("single_gnt_dev", 0);
        repeat (9) step();
        done[0] = 4'b0100;
        req[0]  = 4'b0000;
        step();
        done[0] = 4'b0000;
        check4("single_gnt_drop", gnt[0], 4'b0000);
        check4("single_cs_hold", cs_n[0], 4'b1011);
        wait_for(0, K_CS_HIGH, 10, n);
        check("single_done_to_cs_high", 32'(n), 2);
        wait_for(0, K_IDLE, 10, n);
        check("single_cs_high_to_idle", 32'(n), 4);
        check("single_sel_kept", {30'b0, sel[0]}, 2);

        // Round robin with all four requests held; reset first so device 0
        // has first priority again.
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_gnt.push_back(0);
        exp_gnt.push_back(1);
        exp_gnt.push_back(2);
        exp_gnt.push_back(3);
        exp_gnt.push_back(0);
        req[0] = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_for(0, K_GNT, 30, n);
            observe_gnt("rr_order", 0);
            g = oh_idx(gnt[0]);
            repeat (4) step();
            done[0] = (g >= 0) ? 4'(1 << g) : 4'b0001;
            if (k == 4)
                req[0] = 4'b0000;
            step();
            done[0] = 4'b0000;
            if (k < 4) begin
                wait_for(0, K_CS_HIGH, 10, n);
                check("rr_done_to_cs_high", 32'(n), 2);
                gap_measure(0, hi, hb);
                check("rr_gap_busy_cycles", 32'(hb), 4);
                check("rr_cs_high_cycles", 32'(hi), 5);
            end
        end
        wait_for(0, K_IDLE, 30, n);
        check("rr_done_to_idle", 32'(n), 6);

        // Abort in SETUP: device 1 drops its request one cycle after CS low.
        c0 = gnt_cyc[0];
        req[0] = 4'b0010;
        wait_for(0, K_CS_LOW, 10, n);
        check("abort_cs_lat", 32'(n), 1);
        check4("abort_cs_vec", cs_n[0], 4'b1101);
        step();
        req[0] = 4'b0000;
        step();
        check4("abort_gnt_zero", gnt[0], 4'b0000);
        check4("abort_cs_still_low", cs_n[0], 4'b1101);
        wait_for(0, K_CS_HIGH, 10, n);
        check("abort_hold_cycles", 32'(n), 2);
        check("abort_gap_busy", {31'b0, busy[0]}, 1);
        wait_for(0, K_IDLE, 10, n);
        check("abort_gap_cycles", 32'(n), 4);
        check("abort_never_granted", 32'(gnt_cyc[0] - c0), 0);
        check("abort_sel_kept", {30'b0, sel[0]}, 1);

        // Foreign done is ignored; reset mid-ACTIVE restarts priority at 0.
        exp_gnt.push_back(1);
        req[0] = 4'b0010;
        wait_for(0, K_GNT, 20, n);
        check("fdone_req_to_gnt", 32'(n), 3);
        observe_gnt("fdone_gnt_dev", 0);
        done[0] = 4'b1000;
        step();
        done[0] = 4'b0000;
        step();
        check4("fdone_gnt_kept", gnt[0], 4'b0010);
        check4("fdone_cs_kept", cs_n[0], 4'b1101);
        rst = 1'b1;
        step();
        check4("rst_cs", cs_n[0], 4'b1111);
        check4("rst_gnt", gnt[0], 4'b0000);
        check("rst_busy", {31'b0, busy[0]}, 0);
        check("rst_sel", {30'b0, sel[0]}, 0);
        rst = 1'b0;
        exp_gnt.push_back(0);
        req[0] = 4'b0011;
        wait_for(0, K_GNT, 20, n);
        check("rst_req_to_gnt", 32'(n), 3);
        observe_gnt("rst_priority", 0);
        done[0] = 4'b0001;
        req[0]  = 4'b0000;
        step();
        done[0] = 4'b0000;
        wait_for(0, K_IDLE, 20, n);
        check("rst_done_to_idle", 32'(n), 6);

        // Parameter sweep on the fast and slow instances.
        for (int d = 1; d < 3; d++) begin
            exp_gnt.push_back(3);
            exp_gnt.push_back(0);
            req[d] = 4'b1000;
            wait_for(d, K_CS_LOW, 10, n);
            check("sweep_cs_lat", 32'(n), 1);
            wait_for(d, K_GNT, 20, n);
            check("sweep_cs_to_gnt", 32'(n), 32'(setup_c[d]));
            observe_gnt("sweep_first_dev", d);
            req[d] = 4'b1001;
            repeat (2) step();
            done[d] = 4'b1000;
            req[d]  = 4'b0001;
            step();
            done[d] = 4'b0000;
            check4("sweep_gnt_drop", gnt[d], 4'b0000);
            wait_for(d, K_CS_HIGH, 20, n);
            check("sweep_done_to_cs_high", 32'(n), 32'(hold_c[d]));
            gap_measure(d, hi, hb);
            check("sweep_gap_busy_cycles", 32'(hb), 32'(gap_c[d]));
            check("sweep_cs_high_cycles", 32'(hi), 32'(gap_c[d] + 1));
            check4("sweep_next_cs", cs_n[d], 4'b1110);
            wait_for(d, K_GNT, 20, n);
            check("sweep_cs_to_gnt_2", 32'(n), 32'(setup_c[d]));
            observe_gnt("sweep_second_dev", d);
            done[d] = 4'b0001;
            req[d]  = 4'b0000;
            step();
            done[d] = 4'b0000;
            wait_for(d, K_IDLE, 30, n);
            check("sweep_done_to_idle", 32'(n), 32'(hold_c[d] + gap_c[d]));
        end

        step();
        check("inv_def",  32'(inv_bad[0]), 0);
        check("inv_fast", 32'(inv_bad[1]), 0);
        check("inv_slow", 32'(inv_bad[2]), 0);
        check("sb_drained", 32'(exp_gnt.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
